// File: rtl/stream_to_framebuf_writer.sv
// Captures one fsync/rsync/pdata frame into frame-buffer writes after a start pulse.
// Addresses come from a running row base plus column, so no multiplier is needed.
module stream_to_framebuf_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int ADDR_W     = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  pix_ce_i,
    input  logic                  fsync_i,
    input  logic                  rsync_i,
    input  logic [DATA_WIDTH-1:0] pdata_i,
    output logic [ADDR_W-1:0]     wraddr_o,
    output logic [11:0]           dout_o,
    output logic                  we_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0]     COL_LIM  = CW'(IMG_W);
    localparam logic [RW-1:0]     LAST_ROW = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic                fsync_q, rsync_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [ADDR_W-1:0]   base_q;
    logic                fs_rise, fs_fall, rs_fall, valid, last_row, col_full;
    logic [3:0]          pix_hi;
    logic                unused_low_bits;

    // Edges are only seen on strobed samples, against the previous strobed value.
    assign fs_rise  = pix_ce_i &  fsync_i & ~fsync_q;
    assign fs_fall  = pix_ce_i & ~fsync_i &  fsync_q;
    assign rs_fall  = pix_ce_i & ~rsync_i &  rsync_q;
    assign valid    = pix_ce_i &  fsync_i &  rsync_i;
    assign last_row = (row_q == LAST_ROW);
    assign col_full = (col_q >= COL_LIM);
    assign pix_hi   = pdata_i[DATA_WIDTH-1 -: 4];
    assign unused_low_bits = ^pdata_i[DATA_WIDTH-5:0];

    assign busy_o = (state_q == ARMED) || (state_q == CAPTURE);
    assign done_o = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = ARMED;
            ARMED:   if (fs_rise) state_d = CAPTURE;
            CAPTURE: if ((rs_fall && last_row) || fs_fall) state_d = DONE;
            DONE:    if (start_i) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsync_q  <= 1'b0;
            rsync_q  <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            base_q   <= '0;
            we_o     <= 1'b0;
            wraddr_o <= '0;
            dout_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            we_o <= 1'b0;
            if (pix_ce_i) begin
                fsync_q <= fsync_i;
                rsync_q <= rsync_i;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        err_o  <= 1'b0;
                        col_q  <= '0;
                        row_q  <= '0;
                        base_q <= '0;
                    end
                end
                CAPTURE: begin
                    if (valid) begin
                        if (!col_full) begin
                            we_o     <= 1'b1;
                            wraddr_o <= base_q + ADDR_W'(col_q);
                            dout_o   <= {pix_hi, pix_hi, pix_hi};
                            col_q    <= col_q + CW'(1);
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    if (rs_fall) begin
                        if (col_q != COL_LIM) err_o <= 1'b1;
                        col_q  <= '0;
                        row_q  <= row_q + RW'(1);
                        base_q <= base_q + ROW_STEP;
                    end
                    // A frame end is only an error if the completing row end did not just happen.
                    if (fs_fall && !(rs_fall && last_row)) err_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_to_framebuf_writer.sv
// Self-checking bench: table of frame scenarios plus hand-written arm/reset sequences,
// with a scoreboard queue of expected frame-buffer writes.
module tb_stream_to_framebuf_writer;

    localparam int DW = 10;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_ce = 1'b0;
    logic          fsync = 1'b0;
    logic          rsync = 1'b0;
    logic [DW-1:0] pdata = '0;
    logic [AW-1:0] wraddr;
    logic [11:0]   dout;
    logic          we, busy, done, err;

    always #5 clk = ~clk;

    stream_to_framebuf_writer #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pix_ce_i(pix_ce),
        .fsync_i(fsync), .rsync_i(rsync), .pdata_i(pdata),
        .wraddr_o(wraddr), .dout_o(dout), .we_o(we),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [11:0]   d;
    } wr_t;

    typedef struct {
        int nrows;
        int short_row;
        int short_len;
        int long_row;
        int long_len;
        int gate_row;
        bit toggle;
        bit joint;
        bit exp_err;
        int exp_writes;
        int exp_last;
    } vec_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    vec_t          vecs[7];
    int            checks = 0;
    int            errors = 0;
    int            wr_count = 0;
    int            row_len[16];
    int            gate_row = -1;
    int            gate_col = 7;
    bit            toggle_ce = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [11:0]   d0 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Grey expansion: top nibble of the top byte replicated three times.
    function automatic logic [11:0] exp_dout(input logic [DW-1:0] pd);
        logic [7:0] p;
        p = pd[DW-1:DW-8];
        return 12'(p[7:4]) * 12'h111;
    endfunction

    function automatic logic [DW-1:0] pix(input int r, input int c);
        if (r == 0 && c == 0) return 10'h294;
        return DW'(r * 29 + c * 13 + 7);
    endfunction

    always @(negedge clk) begin
        if (rst_n && we) begin
            if (wr_count == 0) first_addr = wraddr;
            last_addr = wraddr;
            if (wraddr == 0) d0 = dout;
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual addr %0d required no write", wraddr);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wraddr), 32'(mon_e.a));
                check("wr_data", 32'(dout), 32'(mon_e.d));
            end
        end
    end

    task automatic tick(input logic ce, input logic fs, input logic rs, input logic [DW-1:0] pd);
        @(posedge clk);
        #1;
        pix_ce = ce;
        fsync  = fs;
        rsync  = rs;
        pdata  = pd;
    endtask

    task automatic sample(input logic fs, input logic rs, input logic [DW-1:0] pd);
        tick(1'b1, fs, rs, pd);
        if (toggle_ce) tick(1'b0, fs, rs, pd);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic clear_counters();
        wr_count   = 0;
        first_addr = '1;
        last_addr  = '0;
    endtask

    task automatic default_rows();
        for (int r = 0; r < 16; r++) row_len[r] = W;
    endtask

    // Drives a frame and pushes the writes the block should make; stop_row aborts mid-row.
    task automatic drive_frame(input int nrows, input bit joint, input int stop_row);
        wr_t e;
        logic [DW-1:0] pd;
        sample(1'b0, 1'b0, '0);
        sample(1'b0, 1'b0, '0);
        sample(1'b1, 1'b0, '0);
        for (int r = 0; r < nrows; r++) begin
            sample(1'b1, 1'b0, '0);
            for (int c = 0; c < row_len[r]; c++) begin
                if (r == stop_row && c == 5) return;
                if (r == gate_row && c == gate_col) begin
                    repeat (10) tick(1'b0, fsync, rsync, pdata);
                end
                pd = pix(r, c);
                if (r < H && c < W) begin
                    e.a = AW'(r * W + c);
                    e.d = exp_dout(pd);
                    exp_q.push_back(e);
                end
                sample(1'b1, 1'b1, pd);
            end
            if (!(joint && r == nrows - 1)) sample(1'b1, 1'b0, '0);
        end
        sample(1'b0, 1'b0, '0);
        sample(1'b0, 1'b0, '0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic check_frame(input bit exp_err, input int exp_writes, input int exp_last);
        wait_done();
        repeat (2) @(negedge clk);
        check("err", 32'(err), 32'(exp_err));
        check("busy_after_done", 32'(busy), 32'd0);
        check("write_count", 32'(wr_count), 32'(exp_writes));
        check("last_addr", 32'(last_addr), 32'(exp_last));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 7; i++) begin
            default_rows();
            if (vecs[i].short_row >= 0) row_len[vecs[i].short_row] = vecs[i].short_len;
            if (vecs[i].long_row >= 0) row_len[vecs[i].long_row] = vecs[i].long_len;
            gate_row  = vecs[i].gate_row;
            toggle_ce = vecs[i].toggle;
            clear_counters();
            pulse_start();
            check("armed_busy", 32'(busy), 32'd1);
            check("armed_done_clear", 32'(done), 32'd0);
            drive_frame(vecs[i].nrows, vecs[i].joint, -1);
            check_frame(vecs[i].exp_err, vecs[i].exp_writes, vecs[i].exp_last);
            if (i == 0) check("dout_a5", 32'(d0), 32'h0AAA);
        end
    endtask

    initial begin
        vecs[0] = '{nrows:12, short_row:-1, short_len:0,  long_row:-1, long_len:0,  gate_row:3,  toggle:1, joint:0, exp_err:0, exp_writes:192, exp_last:191};
        vecs[1] = '{nrows:12, short_row:5,  short_len:15, long_row:6,  long_len:17, gate_row:-1, toggle:0, joint:0, exp_err:1, exp_writes:191, exp_last:191};
        vecs[2] = '{nrows:5,  short_row:-1, short_len:0,  long_row:-1, long_len:0,  gate_row:-1, toggle:1, joint:0, exp_err:1, exp_writes:80,  exp_last:79};
        vecs[3] = '{nrows:13, short_row:-1, short_len:0,  long_row:-1, long_len:0,  gate_row:-1, toggle:0, joint:0, exp_err:0, exp_writes:192, exp_last:191};
        vecs[4] = '{nrows:12, short_row:11, short_len:15, long_row:-1, long_len:0,  gate_row:-1, toggle:0, joint:0, exp_err:1, exp_writes:191, exp_last:190};
        vecs[5] = '{nrows:12, short_row:-1, short_len:0,  long_row:-1, long_len:0,  gate_row:-1, toggle:1, joint:1, exp_err:0, exp_writes:192, exp_last:191};
        vecs[6] = '{nrows:4,  short_row:-1, short_len:0,  long_row:-1, long_len:0,  gate_row:-1, toggle:0, joint:1, exp_err:1, exp_writes:64,  exp_last:63};

        #1;
        check("reset_we", 32'(we), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_addr", 32'(wraddr), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        #20;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        applyStimulus();

        // Arm while a frame is already running: that frame must be skipped entirely.
        default_rows();
        gate_row  = -1;
        toggle_ce = 1'b1;
        clear_counters();
        sample(1'b0, 1'b0, '0);
        sample(1'b1, 1'b0, '0);
        for (int c = 0; c < 4; c++) sample(1'b1, 1'b1, pix(1, c));
        pulse_start();
        for (int c = 4; c < 8; c++) sample(1'b1, 1'b1, pix(1, c));
        sample(1'b1, 1'b0, '0);
        for (int c = 0; c < 3; c++) sample(1'b1, 1'b1, pix(2, c));
        @(negedge clk);
        check("midframe_busy", 32'(busy), 32'd1);
        check("midframe_no_writes", 32'(wr_count), 32'd0);
        sample(1'b0, 1'b0, '0);
        drive_frame(H, 1'b0, -1);
        check_frame(1'b0, 192, 191);
        check("midframe_first_addr", 32'(first_addr), 32'd0);

        // Asynchronous reset in the middle of row 6 while a write is on the outputs.
        default_rows();
        toggle_ce = 1'b0;
        clear_counters();
        pulse_start();
        drive_frame(H, 1'b0, 6);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        fsync  = 1'b0;
        rsync  = 1'b0;
        #1;
        check("rst_mid_we", 32'(we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        exp_q.delete();
        #15;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'd0);
        clear_counters();
        toggle_ce = 1'b1;
        pulse_start();
        drive_frame(H, 1'b0, -1);
        check_frame(1'b0, 192, 191);
        check("rst_first_addr", 32'(first_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
